// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. The master raises start with a, b and cin
// stable; it is accepted on the first rising edge where busy is low, and done pulses for one cycle with sum/cout valid.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, WIDTH cycles per add.
// The result registers only update when an operation completes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus,
  output logic [1:0]     dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    s       = a_q[0] ^ b_q[0] ^ carry_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          part_d  = '0;
        end
      end
      SHIFT: begin
        carry_d = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // New bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
        part_d  = (part_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = part_d;
          cout_d  = carry_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vectors with literal expectations plus an
// edge-counting model checked on every falling edge.
module tb_serial_adder;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder_if #(.WIDTH(1)) bus1 ();
  logic [1:0] dbg, dbg1;

  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state(dbg));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave), .dbg_state(dbg1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted add finishes WIDTH edges later and stays busy one more edge.
  int         e = 0;
  logic       pend = 1'b0;
  int         done_e = 0;
  logic [W:0] pend_res = '0;
  logic [W:0] last_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     = 1'b0;
      last_res = '0;
    end else begin
      e++;
      if (pend && e == done_e) last_res = pend_res;
      if (!pend) begin
        if (bus.start) begin
          pend     = 1'b1;
          done_e   = e + W;
          pend_res = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
        end
      end else if (e == done_e + 1) begin
        pend = 1'b0;
      end
    end
  end

  int done_cnt = 0;
  int busy_cnt = 0;
  int done_edges[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {31'b0, bus.busy}, {31'b0, pend});
      check("done", {31'b0, bus.done}, {31'b0, pend && (e == done_e)});
      check("sum", {24'b0, bus.sum}, {24'b0, last_res[W-1:0]});
      check("cout", {31'b0, bus.cout}, {31'b0, last_res[W]});
      if (bus.done) begin
        done_cnt++;
        done_edges.push_back(e);
      end
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic pulse(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk); #2;
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = cv;
    @(negedge clk); #2;
    // Scramble operands after acceptance; the add in flight must not see them.
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 255));
    bus.b     = W'($urandom_range(0, 255));
    bus.cin   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int edge_o);
    int ok;
    ok = 0;
    edge_o = -1;
    for (int i = 0; i < 30 && ok == 0; i++) begin
      @(negedge clk); #1;
      if (bus.done) begin
        ok = 1;
        edge_o = e;
      end
    end
    check("done_timeout", ok, 1);
  endtask

  task automatic run(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic cv, input logic [W-1:0] es, input logic ec);
    int k, d;
    pulse(av, bv, cv);
    k = e;
    wait_done(d);
    check({name, "_latency"}, d - k, W);
    check({name, "_sum"}, {24'b0, bus.sum}, {24'b0, es});
    check({name, "_cout"}, {31'b0, bus.cout}, {31'b0, ec});
    check({name, "_model"}, {23'b0, last_res}, {23'b0, ec, es});
  endtask

  logic [W:0] exp_q[$];
  logic [W-1:0] pa[2] = '{8'h12, 8'hF0};
  logic [W-1:0] pb[2] = '{8'h34, 8'h0F};
  logic         pc[2] = '{1'b0, 1'b1};

  initial begin
    int k, d, dc0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_sum", {24'b0, bus.sum}, 0);
    check("rst_cout", {31'b0, bus.cout}, 0);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_state", {30'b0, dbg}, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

    busy_cnt = 0;
    run("5a_plus_3c", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_cycles", busy_cnt, W + 1);

    // A start arriving mid-operation is dropped.
    dc0 = done_cnt;
    pulse(8'h01, 8'h01, 1'b0);
    k = e;
    repeat (2) @(negedge clk);
    #2 bus.start = 1'b1; bus.a = 8'hFF;
    @(negedge clk); #2 bus.start = 1'b0;
    wait_done(d);
    check("ign_latency", d - k, W);
    check("ign_sum", {24'b0, bus.sum}, 32'h02);
    check("ign_cout", {31'b0, bus.cout}, 0);
    repeat (14) @(negedge clk);
    check("ign_single_done", done_cnt - dc0, 1);

    // Reset mid-operation clears outputs without a clock and loses the add.
    pulse(8'h80, 8'h80, 1'b0);
    k = e;
    while (e < k + 3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("abort_sum", {24'b0, bus.sum}, 0);
    check("abort_cout", {31'b0, bus.cout}, 0);
    check("abort_busy", {31'b0, bus.busy}, 0);
    check("abort_done", {31'b0, bus.done}, 0);
    check("abort_state", {30'b0, dbg}, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    run("03_plus_04", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    repeat (2) @(negedge clk);
    done_edges.delete();
    exp_q.delete();
    exp_q.push_back(9'h046); exp_q.push_back(9'h100);
    exp_q.push_back(9'h046); exp_q.push_back(9'h100);
    #2 bus.start = 1'b1; bus.a = pa[0]; bus.b = pb[0]; bus.cin = pc[0];
    for (int i = 0; i < 4; i++) begin
      logic [W:0] ex;
      wait_done(d);
      ex = exp_q.pop_front();
      check("hold_sum", {24'b0, bus.sum}, {24'b0, ex[W-1:0]});
      check("hold_cout", {31'b0, bus.cout}, {31'b0, ex[W]});
      #1 bus.a = pa[(i+1)%2]; bus.b = pb[(i+1)%2]; bus.cin = pc[(i+1)%2];
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_done_count", done_edges.size(), 4);
    for (int i = 1; i < done_edges.size(); i++)
      check("hold_period", done_edges[i] - done_edges[i-1], W + 2);

    // WIDTH=1 instance: done one edge after acceptance.
    @(negedge clk); #2;
    bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
    @(negedge clk); #1;
    check("w1_busy_shift", {31'b0, bus1.busy}, 1);
    check("w1_done_early", {31'b0, bus1.done}, 0);
    #1 bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;
    @(negedge clk); #1;
    check("w1_done", {31'b0, bus1.done}, 1);
    check("w1_sum", {31'b0, bus1.sum}, 1);
    check("w1_cout", {31'b0, bus1.cout}, 1);
    @(negedge clk); #1;
    check("w1_idle", {31'b0, bus1.busy}, 0);
    check("w1_hold_sum", {31'b0, bus1.sum}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
